// File: rtl/fb_scanout.sv
// Framebuffer scan-out: raster-order reads of an RGB565 framebuffer driving a
// 12-bit VGA port, with frame_start/vblank pacing outputs for the renderers.
module fb_scanout #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [18:0] fb_addr,
  output logic        fb_rd,
  input  logic [15:0] fb_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Blanked pixels must show black regardless of what the BRAM returns.
  function automatic logic [11:0] blank_rgb(input logic de, input logic [11:0] c);
    return de ? c : 12'h000;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [18:0]      addr_cnt;
  logic             pix_ce;
  logic             frame_wrap;
  logic             vld_p0, hs_p0, vs_p0;
  logic             vld_p1, hs_p1, vs_p1;
  logic [11:0]      px_444;
  logic             unused_lsbs;

  assign pix_ce     = (div_cnt == DIV_LAST);
  assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign vld_p0     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_p0      = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign vs_p0      = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  assign px_444      = {fb_data[15:12], fb_data[10:7], fb_data[4:1]};
  assign unused_lsbs = ^{fb_data[11], fb_data[6:5], fb_data[0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Stage A: issue the read for the current pixel and capture its timing flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fb_addr     <= '0;
      fb_rd       <= 1'b0;
      addr_cnt    <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      vld_p1      <= 1'b0;
      hs_p1       <= 1'b0;
      vs_p1       <= 1'b0;
    end else begin
      fb_rd       <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        if (vld_p0) begin
          fb_addr  <= addr_cnt;
          fb_rd    <= 1'b1;
          addr_cnt <= addr_cnt + 19'd1;
        end
        if (frame_wrap) begin
          addr_cnt    <= '0;
          frame_start <= 1'b1;
        end
        vblank <= (v_cnt >= V_ACT);
        vld_p1 <= vld_p0;
        hs_p1  <= hs_p0;
        vs_p1  <= vs_p0;
      end
    end
  end

  // Stage B: read data has settled by the next pix_ce; drive the VGA port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
    end else if (pix_ce) begin
      {vga_r, vga_g, vga_b} <= blank_rgb(vld_p1, px_444);
      vga_hs                <= ~hs_p1;
      vga_vs                <= ~vs_p1;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a reduced 8x4 raster (15x8 total) so
// several frames, the blanking regions and a mid-frame reset fit in a short run.
module tb_fb_scanout;

  localparam int CD = 4;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [18:0] fb_addr;
  logic        fb_rd;
  logic [15:0] fb_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start, vblank;

  logic [15:0] mem [0:31];
  logic [18:0] addr_q;
  logic [15:0] dout;
  logic        ffff_mode;

  exp_t        pq[$];
  logic [18:0] aq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  int          fs_cnt = 0;
  int          first_fs = -1;

  fb_scanout #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rstn(rstn), .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 clk = ~clk;

  // Registered BRAM: address captured, then data registered -> 2 clk latency
  always @(posedge clk) begin
    addr_q <= fb_addr;
    dout   <= mem[addr_q[4:0]];
  end
  assign fb_data = ffff_mode ? 16'hFFFF : dout;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int a);
    logic [3:0] n;
    case (a)
      0: return 12'hF00;
      1: return 12'h0F0;
      2: return 12'h00F;
      3: return 12'h14A;
      default: begin
        n = 4'(a % 16);
        return {n, n, n};
      end
    endcase
  endfunction

  // Expected pixel n appears on the VGA port after posedge 4n+8 since release;
  // its read is issued after posedge 4n+4.
  task automatic push_phase(input int n, input bit ff);
    exp_t e;
    for (int p = 0; p < n + 2; p++) begin
      int pix, h, v, pn;
      bit act;
      pix = p % FRAME;
      h = pix % HT;
      v = pix / HT;
      act = (h < HA) && (v < VA);
      if (act) aq.push_back(19'(v * HA + h));
      if (p < n) begin
        pn = (p + 1) % FRAME;
        e.rgb = act ? (ff ? 12'hFFF : exp_rgb(v * HA + h)) : 12'h000;
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e.vb = ((pn / HT) >= VA);
        pq.push_back(e);
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst fb_addr", fb_addr, 0);
    chk("rst fb_rd", fb_rd, 0);
    chk("rst rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst vga_hs", vga_hs, 1);
    chk("rst vga_vs", vga_vs, 1);
    chk("rst frame_start", frame_start, 0);
    chk("rst vblank", vblank, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    pq.delete();
    aq.delete();
    fs_cnt = 0;
    first_fs = -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (pq.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({name, " drain timeout"}, (pq.size() != 0), 0);
  endtask

  // Pixel monitor
  always @(negedge clk) begin
    if (rstn && cyc >= 8 && cyc % CD == 0 && pq.size() > 0) begin
      exp_t e;
      int pi;
      e = pq.pop_front();
      pi = cyc / CD - 2;
      chk($sformatf("rgb px%0d", pi), {vga_r, vga_g, vga_b}, e.rgb);
      chk($sformatf("vga_hs px%0d", pi), vga_hs, e.hs);
      chk($sformatf("vga_vs px%0d", pi), vga_vs, e.vs);
      chk($sformatf("vblank px%0d", pi), vblank, e.vb);
    end
  end

  // Read monitor
  always @(negedge clk) begin
    if (rstn && fb_rd) begin
      chk($sformatf("fb_rd phase cyc%0d", cyc), cyc % CD, 0);
      if (aq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=%0h expected=none", fb_addr);
      end else begin
        chk($sformatf("fb_addr cyc%0d", cyc), fb_addr, aq.pop_front());
      end
    end
  end

  // frame_start monitor: one clk wide, after the pix_ce of the last pixel
  always @(negedge clk) begin
    if (rstn) begin
      logic exp_fs;
      exp_fs = (cyc >= CD) && (cyc % CD == 0) && (((cyc / CD - 1) % FRAME) == FRAME - 1);
      chk($sformatf("frame_start cyc%0d", cyc), frame_start, exp_fs);
      if (frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = cyc;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    ffff_mode = 1'b0;
    for (int i = 0; i < 32; i++)
      mem[i] = 16'((i % 16) << 12) | 16'((i % 16) << 7) | 16'((i % 16) << 1);
    mem[0] = 16'hF800;
    mem[1] = 16'h07E0;
    mem[2] = 16'h001F;
    mem[3] = 16'h1234;
    #23 chk_reset_vals();

    // Two full frames plus wrap into the third
    push_phase(2 * FRAME + 2, 1'b0);
    release_reset();
    wait_drain("phase1");
    chk("phase1 frame_start count", fs_cnt, 2);
    chk("phase1 first frame_start cyc", first_fs, CD * FRAME);

    // Constant white data: blanking must still show black
    do_reset();
    ffff_mode = 1'b1;
    push_phase(FRAME, 1'b1);
    release_reset();
    wait_drain("phase2");
    chk("phase2 frame_start count", fs_cnt, 1);

    // Mid-frame reset, then a clean restart from (0,0)
    do_reset();
    ffff_mode = 1'b0;
    push_phase(36, 1'b0);
    release_reset();
    wait_drain("phase3");
    chk("midframe addr nonzero", (fb_addr != 0), 1);
    do_reset();
    push_phase(FRAME + 2, 1'b0);
    release_reset();
    wait_drain("phase4");
    chk("phase4 frame_start count", fs_cnt, 1);
    chk("phase4 first frame_start cyc", first_fs, CD * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
